handshake_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single multi-bit CDC handshake transmit channel among N requesters in the `clk_tx` domain. It grants one requester at a time and presents that requester's word to the handshake transmitter as a one-cycle `data_en` strobe with data. It then tracks the transmitter's `data_req` through a full rise/fall cycle before the channel is re-armed. A watchdog aborts a transfer whose handshake stalls.

---
 rtl/handshake_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_handshake_tx_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/handshake_tx_arbiter.sv
// Round-robin arbiter that shares one CDC handshake transmit channel among N
// requesters, sequencing launch / req-rise / req-fall with a per-state watchdog.
module handshake_tx_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 4,
  parameter int TO_CYCLES = 64
) (
  input  logic                 clk_tx,
  input  logic                 rst_n,
  input  logic [N-1:0]         src_valid,
  input  logic [N*DW-1:0]      src_data,
  output logic [N-1:0]         src_ready,
  output logic                 hs_data_en,
  output logic [DW-1:0]        hs_data_in,
  input  logic                 hs_data_req,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           err_cnt
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TO_CYCLES);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_RISE, WAIT_FALL} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;
  logic [DW-1:0] win_word;
  logic          win_found;
  logic          accept;
  logic [CW-1:0] wd_cnt, wd_cnt_next;
  logic          wd_expired;
  logic          done_next, err_next;

  // Winner is the first valid requester at or above ptr, wrapping at N-1.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    win_word  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr) + k) % N);
      if (!win_found && src_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (win_idx == IW'(k)) win_word = src_data[k*DW +: DW];
    end
  end

  // A stale hs_data_req (e.g. left over after an abort) blocks any new launch.
  assign accept    = rst_n && (state == IDLE) && !hs_data_req && win_found;
  assign src_ready = accept ? (N'(1) << win_idx) : '0;
  assign busy      = (state != IDLE);
  assign wd_expired = (wd_cnt == CW'(TO_CYCLES - 1));

  always_comb begin
    state_next  = state;
    wd_cnt_next = wd_cnt;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = LAUNCH;
      end
      LAUNCH: begin
        state_next  = WAIT_RISE;
        wd_cnt_next = '0;
      end
      WAIT_RISE: begin
        // The awaited edge is tested before expiry so it wins a tie.
        if (hs_data_req) begin
          state_next  = WAIT_FALL;
          wd_cnt_next = '0;
        end else if (wd_expired) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt + 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!hs_data_req) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (wd_expired) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_tx) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      wd_cnt     <= '0;
      hs_data_en <= 1'b0;
      hs_data_in <= '0;
      grant_id   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_next;
      wd_cnt     <= wd_cnt_next;
      done       <= done_next;
      err        <= err_next;
      hs_data_en <= accept;
      if (accept) begin
        hs_data_in <= win_word;
        grant_id   <= win_idx;
        ptr        <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
      if (err_next && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_handshake_tx_arbiter.sv
// Self-checking bench: directed steps plus randomized transfers predicted by a
// transaction-level round-robin / handshake-timing model.
module tb_handshake_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int TO = 8;
  localparam int IW = $clog2(N);

  logic              clk_tx = 1'b0;
  logic              rst_n;
  logic [N-1:0]      src_valid;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_ready;
  logic              hs_data_en;
  logic [DW-1:0]     hs_data_in;
  logic              hs_data_req;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        err_cnt;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int m_err = 0;

  handshake_tx_arbiter #(.N(N), .DW(DW), .TO_CYCLES(TO)) dut (
    .clk_tx      (clk_tx),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .hs_data_en  (hs_data_en),
    .hs_data_in  (hs_data_in),
    .hs_data_req (hs_data_req),
    .grant_id    (grant_id),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  always #5 clk_tx = ~clk_tx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_tx);
    #1;
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_en"},      hs_data_en, 0);
    check({tag, "_data_in"}, hs_data_in, 0);
    check({tag, "_grant"},   grant_id,   0);
    check({tag, "_busy"},    busy,       0);
    check({tag, "_done"},    done,       0);
    check({tag, "_err"},     err,        0);
    check({tag, "_err_cnt"}, err_cnt,    0);
    check({tag, "_ready"},   src_ready,  0);
  endtask

  // One transfer starting in an IDLE cycle. The transmitter raises req d1
  // cycles after the hs_data_en cycle (d1==0: never) and holds it h cycles.
  task automatic run_txn(input logic [N-1:0] v, input logic [N*DW-1:0] data,
                         input int d1, input int h);
    int w, t_end;
    bit ok;
    logic [DW-1:0] word;
    src_valid = v;
    src_data  = data;
    #1;
    w    = rr_winner(v, m_ptr);
    word = data[w*DW +: DW];
    check("idle_busy", busy, 0);
    check("accept_ready", src_ready, 1 << w);
    // WAIT_RISE is entered 2 cycles after accept; each wait state allows
    // TO cycles, and the edge wins in the last one.
    if (d1 == 0 || d1 > TO) begin
      ok = 0; t_end = TO + 2;
    end else if (h > TO) begin
      ok = 0; t_end = d1 + TO + 2;
    end else begin
      ok = 1; t_end = d1 + h + 2;
    end
    m_ptr = (w + 1) % N;
    for (int t = 1; t <= t_end; t++) begin
      tick;
      hs_data_req = (d1 != 0) && (t >= 1 + d1) && (t < 1 + d1 + h);
      #1;
      if (t == t_end && !ok && m_err < 255) m_err++;
      check("data_en", hs_data_en, t == 1);
      check("busy",    busy,       t < t_end);
      check("done",    done,       ok && t == t_end);
      check("err",     err,        !ok && t == t_end);
      check("data_in", hs_data_in, word);
      check("err_cnt", err_cnt,    m_err);
      if (t < t_end) begin
        check("grant_id",   grant_id,  w);
        check("ready_busy", src_ready, 0);
      end else begin
        check("ready_idle", src_ready, hs_data_req ? 0 : (1 << rr_winner(v, m_ptr)));
      end
    end
    src_valid   = '0;
    hs_data_req = 1'b0;
  endtask

  initial begin
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rd;
    int              r1, rh;

    // Reset: src_ready stays low even with every requester valid.
    rst_n       = 1'b0;
    src_valid   = '1;
    src_data    = 16'h1234;
    hs_data_req = 1'b0;
    #1;
    check("rst_ready_comb", src_ready, 0);
    tick;
    tick;
    check_reset("rst");
    rst_n     = 1'b1;
    src_valid = '0;

    // Round robin from reset with a fastest transmitter: grants 0,1,2,3,0
    // spaced 4 cycles apart.
    for (int i = 0; i < 5; i++) run_txn('1, 16'hFEDC, 1, 1);

    // Single word from requester 2.
    run_txn(4'b0100, 16'h5A3C, 3, 5);
    check("single_grant_id", grant_id, 2);

    // Back-pressure: a high hs_data_req blocks the accept until it drops.
    hs_data_req = 1'b1;
    src_valid   = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", src_ready, 0);
      tick;
      check("bp_busy", busy, 0);
    end
    hs_data_req = 1'b0;
    run_txn(4'b0001, 16'h0007, 1, 1);

    // Watchdog: req never rises.
    run_txn(4'b0010, 16'h00B0, 0, 0);
    check("wd_err_cnt_one", err_cnt, 1);

    // Edge vs expiry in both wait states, then a fall timeout leaving a stale req.
    run_txn(4'b1000, 16'hC000, 1, TO);
    run_txn(4'b0110, 16'h0DE0, TO, 2);
    run_txn(4'b1001, 16'h9009, 2, TO + 1);
    run_txn(4'b0011, 16'h0021, 1, TO + 3);

    // Randomized transfers.
    for (int i = 0; i < 40; i++) begin
      rv = N'($urandom_range(1, (1 << N) - 1));
      rd = (N*DW)'($urandom);
      r1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
      rh = $urandom_range(1, TO + 3);
      run_txn(rv, rd, r1, rh);
      if ($urandom_range(0, 1) == 1) tick;
    end

    // Repeated aborts saturate err_cnt.
    for (int i = 0; i < 300; i++) run_txn(4'b0100, (N*DW)'($urandom), 0, 0);
    check("err_cnt_sat", err_cnt, 255);

    // Mid-transfer reset while in WAIT_FALL.
    src_valid = '1;
    #1;
    check("mid_accept", src_ready, 1 << rr_winner('1, m_ptr));
    tick;
    check("mid_launch", hs_data_en, 1);
    hs_data_req = 1'b1;
    tick;
    tick;
    check("mid_busy", busy, 1);
    rst_n       = 1'b0;
    hs_data_req = 1'b0;
    #1;
    check("mid_rst_ready", src_ready, 0);
    tick;
    check_reset("mid_rst");
    rst_n = 1'b1;
    m_ptr = 0;
    m_err = 0;
    #1;
    check("mid_ptr0", src_ready, 1);
    run_txn('1, 16'h4321, 2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
